// File: rtl/tdm_pkg.sv
// Shared constants for the 8:1 TDM receive path: default geometry, FSM
// state encoding and the frame parity helper.
// Optional feature macro used by the design: FRAME_PARITY_EN.
package tdm_pkg;

    localparam int TDM_CHANNELS = 8;
    localparam int TDM_SEL_W    = 3;

    // FSM state encoding
    localparam logic HUNT = 1'b0;
    localparam logic RECV = 1'b1;

    // Even-parity bit over up to 16 frame bits (unused upper bits must be zero)
    function automatic logic even_par16(input logic [15:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/tdm_demux8_demux_dec.sv
// Slot index to one-hot write-enable decoder. When enabled, exactly one
// bit is set; it drives the channel strobes and the shadow write enables.
module demux_dec
    import tdm_pkg::*;
#(
    parameter int CHANNELS = TDM_CHANNELS,
    parameter int SEL_W    = TDM_SEL_W
) (
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    output logic [CHANNELS-1:0] onehot
);

    // One-hot decode of sel, gated by en
    always_comb begin
        onehot = {CHANNELS{1'b0}};
        if (en) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = {CHANNELS{1'b0}};
        end
    end

endmodule

// File: rtl/tdm_demux8.sv
// Receive side of the 8:1 TDM serial link. Tracks the transmitter's slot
// walk, collects each sample into a shadow register and publishes the frame
// with a one-cycle valid once the last slot arrives.
// Optional feature macro: FRAME_PARITY_EN (adds an even-parity slot after
// the last data slot and the par_err output).
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int CHANNELS = TDM_CHANNELS,
    parameter int SEL_W    = TDM_SEL_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                din,
    input  logic                sync_in,
    output logic [SEL_W-1:0]    ch_sel,
    output logic [CHANNELS-1:0] ch_strobe,
    output logic [CHANNELS-1:0] frame_out,
    output logic                frame_valid,
    output logic                sync_err
`ifdef FRAME_PARITY_EN
    ,
    output logic                par_err
`endif
);

    // The slot counter needs one extra bit to reach the parity slot index.
`ifdef FRAME_PARITY_EN
    localparam int CNT_W = SEL_W + 1;
    localparam logic [CNT_W-1:0] PAR_SLOT = CNT_W'(CHANNELS);
`else
    localparam int CNT_W = SEL_W;
`endif
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(CHANNELS - 1);

    logic                state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0] frame_q, frame_d;
    logic                frame_valid_q, frame_valid_d;
    logic                sync_err_q, sync_err_d;
`ifdef FRAME_PARITY_EN
    logic                par_err_q, par_err_d;
`endif

    logic                data_slot_s;
    logic                wr_go_s;
    logic [SEL_W-1:0]    wr_idx_s;
    logic [CHANNELS-1:0] wr_en_s;

    // Decide which shadow slot (if any) this sample lands in; a sync always re-bases to slot 0
    always_comb begin
`ifdef FRAME_PARITY_EN
        data_slot_s = (cnt_q != PAR_SLOT);
`else
        data_slot_s = 1'b1;
`endif
        if (sync_in) begin
            wr_idx_s = {SEL_W{1'b0}};
        end else begin
            wr_idx_s = cnt_q[SEL_W-1:0];
        end
        wr_go_s = en & (sync_in | ((state_q == RECV) & (cnt_q != CNT_ZERO) & data_slot_s));
    end

    demux_dec #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_dec (
        .en     (wr_go_s),
        .sel    (wr_idx_s),
        .onehot (wr_en_s)
    );

    // Framing FSM, slot counter, shadow capture and frame publication
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
`ifdef FRAME_PARITY_EN
        par_err_d     = 1'b0;
`endif
        if (!en) begin
            state_d = state_q;
        end else if (sync_in) begin
            // A sync anywhere but slot 0 of a running frame is a framing error;
            // either way the bit starts a fresh frame.
            sync_err_d = (state_q == RECV) && (cnt_q != CNT_ZERO);
            shadow_d   = wr_en_s & {CHANNELS{din}};
            cnt_d      = CNT_ONE;
            state_d    = RECV;
        end else begin
            case (state_q)
                HUNT: begin
                    state_d = HUNT;
                end
                RECV: begin
                    if (cnt_q == CNT_ZERO) begin
                        // Slot 0 without sync: lost alignment, drop sample and re-hunt
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        cnt_d      = CNT_ZERO;
`ifdef FRAME_PARITY_EN
                    end else if (cnt_q == PAR_SLOT) begin
                        if (even_par16(16'(shadow_q)) == din) begin
                            frame_d       = shadow_q;
                            frame_valid_d = 1'b1;
                        end else begin
                            par_err_d = 1'b1;
                        end
                        cnt_d = CNT_ZERO;
`else
                    end else if (cnt_q == LAST_SLOT) begin
                        frame_d       = {din, shadow_q[CHANNELS-2:0]};
                        frame_valid_d = 1'b1;
                        cnt_d         = CNT_ZERO;
`endif
                    end else begin
                        shadow_d = (shadow_q & ~wr_en_s) | (wr_en_s & {CHANNELS{din}});
                        cnt_d    = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= HUNT;
            cnt_q         <= CNT_ZERO;
            shadow_q      <= {CHANNELS{1'b0}};
            frame_q       <= {CHANNELS{1'b0}};
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
`ifdef FRAME_PARITY_EN
            par_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
`ifdef FRAME_PARITY_EN
            par_err_q     <= par_err_d;
`endif
        end
    end

    // At the parity slot ch_sel reads 0; the slot is not a channel.
    assign ch_sel      = cnt_q[SEL_W-1:0];
    assign ch_strobe   = wr_en_s;
    assign frame_out   = frame_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
`ifdef FRAME_PARITY_EN
    assign par_err     = par_err_q;
`endif

    // LAST_SLOT only drives logic in the non-parity build
`ifdef FRAME_PARITY_EN
    logic unused_last_s;
    assign unused_last_s = ^LAST_SLOT;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: directed vector table, hand-written
// multi-cycle sequences (frame spacing, async reset) and a randomized run
// against a slot-position reference model.
module tb_tdm_demux8;
    import tdm_pkg::*;

    localparam int CH = 8;
`ifdef FRAME_PARITY_EN
    localparam int SLOTS = CH + 1;
`else
    localparam int SLOTS = CH;
`endif

    logic       clk = 1'b0;
    logic       reset, en, din, sync_in;
    logic [2:0] ch_sel;
    logic [7:0] ch_strobe, frame_out;
    logic       frame_valid, sync_err;
`ifdef FRAME_PARITY_EN
    logic       par_err;
`endif

    tdm_demux8 dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .din         (din),
        .sync_in     (sync_in),
        .ch_sel      (ch_sel),
        .ch_strobe   (ch_strobe),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
`ifdef FRAME_PARITY_EN
        ,
        .par_err     (par_err)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_locked;
    int         m_pos;
    bit [7:0]   m_bits;
    logic [7:0] m_frame;
    bit         m_valid, m_serr, m_perr;

    task automatic model_reset();
        m_locked = 1'b0; m_pos = 0; m_bits = 8'h00; m_frame = 8'h00;
        m_valid = 1'b0; m_serr = 1'b0; m_perr = 1'b0;
    endtask

    function automatic logic [7:0] model_strobe(input bit e, input bit s);
        if (!e) return 8'h00;
        if (s) return 8'h01;
        if (m_locked && m_pos != 0 && m_pos < CH) return 8'h01 << m_pos;
        return 8'h00;
    endfunction

    task automatic model_step(input bit e, input bit d, input bit s);
        m_valid = 1'b0; m_serr = 1'b0; m_perr = 1'b0;
        if (e) begin
            if (s) begin
                if (m_locked && m_pos != 0) m_serr = 1'b1;
                m_bits = 8'h00; m_bits[0] = d; m_pos = 1; m_locked = 1'b1;
            end else if (!m_locked) begin
                m_pos = 0;
            end else if (m_pos == 0) begin
                m_serr = 1'b1; m_locked = 1'b0;
            end else if (m_pos < CH) begin
                m_bits[m_pos] = d;
                m_pos++;
                if (SLOTS == CH && m_pos == CH) begin
                    m_frame = m_bits; m_valid = 1'b1; m_pos = 0;
                end
            end else begin
                if ((($countones(m_bits) + int'(d)) % 2) == 0) begin
                    m_frame = m_bits; m_valid = 1'b1;
                end else begin
                    m_perr = 1'b1;
                end
                m_pos = 0;
            end
        end
    endtask

    // One clock of stimulus checked against the model; entered at posedge+1
    task automatic cycle(input bit e, input bit d, input bit s);
        en = e; din = d; sync_in = s;
        #1;
        chk("strobe", 32'(ch_strobe), 32'(model_strobe(e, s)));
        model_step(e, d, s);
        @(posedge clk); #1;
        chk("sel", 32'(ch_sel), 32'(m_pos % CH));
        chk("frame", 32'(frame_out), 32'(m_frame));
        chk("valid", 32'(frame_valid), 32'(m_valid));
        chk("serr", 32'(sync_err), 32'(m_serr));
`ifdef FRAME_PARITY_EN
        chk("perr", 32'(par_err), 32'(m_perr));
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       e, d, s;
        logic [2:0] sel;
        logic       valid;
        logic [7:0] frame;
        logic       serr, perr;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_frame;

    task automatic add_vec(input logic e, input logic d, input logic s, input logic [2:0] sel,
                           input logic v, input logic [7:0] f, input logic se, input logic pe);
        vec_t r;
        r.e = e; r.d = d; r.s = s; r.sel = sel; r.valid = v;
        r.frame = f; r.serr = se; r.perr = pe;
        vecs.push_back(r);
    endtask

    // Slots first..7 of frame f (sync on slot 0), optional idle gaps, parity slot if built
    task automatic add_frame(input logic [7:0] f, input bit gaps, input bit good_par, input int first);
        logic [7:0] rf;
        bit         done;
        for (int k = first; k < CH; k++) begin
            done = (SLOTS == CH) && (k == CH - 1);
            rf   = done ? f : exp_frame;
            add_vec(1'b1, f[k], k == 0, 3'((k + 1) % CH), done, rf, 1'b0, 1'b0);
            if (gaps) add_vec(1'b0, ~f[k], 1'b1, 3'((k + 1) % CH), 1'b0, rf, 1'b0, 1'b0);
        end
        if (SLOTS == CH) begin
            exp_frame = f;
        end else begin
            add_vec(1'b1, (^f) ^ !good_par, 1'b0, 3'd0, good_par,
                    good_par ? f : exp_frame, 1'b0, !good_par);
            if (good_par) exp_frame = f;
        end
    endtask

    int t_first, t_second, n_valid;

    initial begin
        reset = 1'b1; en = 1'b0; din = 1'b0; sync_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_frame", 32'(frame_out), 32'h0);
        chk("rst_sel", 32'(ch_sel), 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'h0);
        chk("rst_serr", 32'(sync_err), 32'h0);
        chk("rst_strobe", 32'(ch_strobe), 32'h0);
        reset = 1'b0;

        // Build table
        exp_frame = 8'h00;
        add_frame(8'h4D, 1'b0, 1'b1, 0);
        add_vec(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h4D, 1'b0, 1'b0);
        add_frame(8'hFF, 1'b1, 1'b1, 0);
        add_frame(8'hA5, 1'b0, 1'b1, 0);
        add_vec(1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 8'hA5, 1'b0, 1'b0);
        for (int k = 1; k < 4; k++) add_vec(1'b1, 1'b0, 1'b0, 3'(k + 1), 1'b0, 8'hA5, 1'b0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 8'hA5, 1'b1, 1'b0);
        add_frame(8'h81, 1'b0, 1'b1, 1);
        add_vec(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h81, 1'b1, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h81, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h81, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h81, 1'b0, 1'b0);
        add_frame(8'h3C, 1'b0, 1'b1, 0);
`ifdef FRAME_PARITY_EN
        add_frame(8'h5A, 1'b0, 1'b0, 0);
`endif

        // Apply table
        foreach (vecs[i]) begin
            en = vecs[i].e; din = vecs[i].d; sync_in = vecs[i].s;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_sel", i), 32'(ch_sel), 32'(vecs[i].sel));
            chk($sformatf("vec%0d_valid", i), 32'(frame_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_frame", i), 32'(frame_out), 32'(vecs[i].frame));
            chk($sformatf("vec%0d_serr", i), 32'(sync_err), 32'(vecs[i].serr));
`ifdef FRAME_PARITY_EN
            chk($sformatf("vec%0d_perr", i), 32'(par_err), 32'(vecs[i].perr));
`endif
        end

        // Back-to-back frames: valid pulses exactly one frame length apart
        en = 1'b0;
        reset = 1'b1; #2; reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        t_first = -1; t_second = -1; n_valid = 0;
        for (int c = 0; c < 2 * SLOTS; c++) begin
            logic [7:0] f;
            int         k;
            f = (c < SLOTS) ? 8'hA5 : 8'h3C;
            k = c % SLOTS;
            if (k < CH) cycle(1'b1, f[k], k == 0);
            else cycle(1'b1, ^f, 1'b0);
            if (frame_valid) begin
                n_valid++;
                if (t_first < 0) t_first = c; else t_second = c;
            end
        end
        chk("b2b_count", 32'(n_valid), 32'd2);
        chk("b2b_spacing", 32'(t_second - t_first), 32'(SLOTS));
        chk("b2b_frame", 32'(frame_out), 32'h3C);

        // Reset mid-frame (ch_sel at 5): outputs clear without a clock edge
        cycle(1'b1, 1'b1, 1'b1);
        for (int k = 1; k < 5; k++) cycle(1'b1, 1'b1, 1'b0);
        chk("pre_rst_sel", 32'(ch_sel), 32'd5);
        en = 1'b0; sync_in = 1'b0;
        #2; reset = 1'b1; #1;
        chk("async_frame", 32'(frame_out), 32'h0);
        chk("async_sel", 32'(ch_sel), 32'h0);
        chk("async_valid", 32'(frame_valid), 32'h0);
        chk("async_serr", 32'(sync_err), 32'h0);
        @(negedge clk); reset = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Randomized run against the model
        for (int c = 0; c < 1500; c++) begin
            bit e, d, s;
            e = ($urandom_range(0, 3) != 0);
            d = 1'($urandom_range(0, 1));
            if (m_pos == 0) s = ($urandom_range(0, 9) != 0);
            else s = ($urandom_range(0, 19) == 0);
            if (m_pos == CH && $urandom_range(0, 1) == 1) d = ^m_bits;
            cycle(e, d, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
